// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU data port (m0) and the debug/loader port (m1).
// Latency from the grant edge: writes complete in 2 cycles, reads in 2+MEM_LAT cycles, with one transaction in flight at a time.
// Backpressure: gnt is only raised in IDLE, and a requester holds req and its payload until it sees gnt at a rising edge.
//
// Ports:
//   clk, rst          : rising-edge clock, asynchronous active-low reset
//   mN_req/we/addr/wdata : request side of master N (N = 0 CPU, 1 debug)
//   mN_gnt            : combinational accept, IDLE only, at most one high
//   mN_rvalid/rdata   : one-cycle completion pulse; rdata holds between pulses
//   mem_en/we/addr/wdata/rdata : single-port memory interface
//   perf_clr, perf_m0_cnt, perf_m1_cnt : grant counters, present only with DATA_MEM_ARB_PERF_EN
module data_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
`ifdef DATA_MEM_ARB_PERF_EN
  input  logic          perf_clr,
  output logic [31:0]   perf_m0_cnt,
  output logic [31:0]   perf_m1_cnt,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // The wait counter is 4 bits wide, so latencies beyond 15 cannot be sequenced.
  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
      $error("data_mem_arbiter: MEM_LAT must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q;      // 0 = m0, 1 = m1
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    cnt_q;
  logic [DW-1:0] rdata_q;
  logic          rr_last_q;    // owner of the most recent grant
  logic [DW-1:0] m0_hold_q;
  logic [DW-1:0] m1_hold_q;
  logic [DW-1:0] resp_data;

  // Writes complete with zero data; reads return what was captured in WAIT.
  assign resp_data = we_q ? '0 : rdata_q;

  // Address and write data come straight from the latched request, so they
  // stay put outside ACCESS and only mem_en qualifies them.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    state_d   = state_q;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = m0_hold_q;
    m1_rdata  = m1_hold_q;
    case (state_q)
      IDLE: begin
        // On a tie the master that did not win last time goes first.
        m0_gnt = m0_req & (~m1_req | rr_last_q);
        m1_gnt = m1_req & (~m0_req | ~rr_last_q);
        if (m0_gnt || m1_gnt) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_en  = 1'b1;
        mem_we  = we_q;
        state_d = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (owner_q) begin
          m1_rvalid = 1'b1;
          m1_rdata  = resp_data;
        end else begin
          m0_rvalid = 1'b1;
          m0_rdata  = resp_data;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= 4'd0;
      rdata_q   <= '0;
      rr_last_q <= 1'b1;
      m0_hold_q <= '0;
      m1_hold_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (m0_gnt || m1_gnt) begin
            owner_q   <= m1_gnt;
            we_q      <= m1_gnt ? m1_we    : m0_we;
            addr_q    <= m1_gnt ? m1_addr  : m0_addr;
            wdata_q   <= m1_gnt ? m1_wdata : m0_wdata;
            rr_last_q <= m1_gnt;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            cnt_q <= 4'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            rdata_q <= mem_rdata;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          // Keep the delivered word visible on the owner's rdata afterwards.
          if (owner_q) begin
            m1_hold_q <= resp_data;
          end else begin
            m0_hold_q <= resp_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DATA_MEM_ARB_PERF_EN
  // Grant counters; clear wins over a same-cycle increment, and both saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_m0_cnt <= '0;
      perf_m1_cnt <= '0;
    end else if (perf_clr) begin
      perf_m0_cnt <= '0;
      perf_m1_cnt <= '0;
    end else begin
      if (m0_gnt && perf_m0_cnt != 32'hFFFF_FFFF) begin
        perf_m0_cnt <= perf_m0_cnt + 32'd1;
      end
      if (m1_gnt && perf_m1_cnt != 32'hFFFF_FFFF) begin
        perf_m1_cnt <= perf_m1_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

`ifdef DATA_MEM_ARB_PERF_EN
  logic        perf_clr, b_perf_clr;
  logic [31:0] perf_m0_cnt, perf_m1_cnt, b_perf_m0_cnt, b_perf_m1_cnt;
`endif

  int checks;
  int errors;
  int cyc;

  typedef struct { int m; logic [31:0] d; int c; } rsp_t;
  typedef struct { int c; logic we; logic [31:0] a; logic [31:0] w; } acc_t;
  rsp_t sb_q[$];
  acc_t acc_q[$];

  data_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT_A)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef DATA_MEM_ARB_PERF_EN
    .perf_clr(perf_clr), .perf_m0_cnt(perf_m0_cnt), .perf_m1_cnt(perf_m1_cnt),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  data_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT_B)) u_dut_lat3 (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
`ifdef DATA_MEM_ARB_PERF_EN
    .perf_clr(b_perf_clr), .perf_m0_cnt(b_perf_m0_cnt), .perf_m1_cnt(b_perf_m1_cnt),
`endif
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten locations return a fixed pattern; 0x10 holds 0xDEADBEEF.
  function automatic logic [31:0] pat(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEAD_BEEF : {24'hC0FFEE, a};
  endfunction

  // Single-port synchronous memory shared by both instances (B only reads).
  initial begin
    logic [31:0] mem [256];
    logic [255:0] wr_vld;
    wr_vld = '0;
    mem_rdata = '0;
    b_mem_rdata = '0;
    forever begin
      @(posedge clk);
      mem_rdata   <= wr_vld[mem_addr[7:0]] ? mem[mem_addr[7:0]] : pat(mem_addr[7:0]);
      b_mem_rdata <= wr_vld[b_mem_addr[7:0]] ? mem[b_mem_addr[7:0]] : pat(b_mem_addr[7:0]);
      if (mem_en && mem_we) begin
        mem[mem_addr[7:0]] = mem_wdata;
        wr_vld[mem_addr[7:0]] = 1'b1;
      end
    end
  end

  // Scoreboard for instance A: expectations pushed at each observed grant
  // from the request the bench is driving, popped at mem_en and rvalid.
  initial begin
    logic [31:0] ref_mem [256];
    logic [255:0] ref_vld;
    rsp_t r;
    acc_t a;
    int m, lat;
    logic we, rv;
    logic [31:0] ad, wd, d, rd;
    ref_vld = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        checks++;
        if (m0_gnt && m1_gnt) begin
          errors++;
          $display("FAIL gnt_exclusive cyc=%0d m0_gnt=%b m1_gnt=%b required at most one", cyc, m0_gnt, m1_gnt);
        end
        if (m0_gnt || m1_gnt) begin
          m  = m0_gnt ? 0 : 1;
          we = m0_gnt ? m0_we : m1_we;
          ad = m0_gnt ? m0_addr : m1_addr;
          wd = m0_gnt ? m0_wdata : m1_wdata;
          if (we) begin
            ref_mem[ad[7:0]] = wd;
            ref_vld[ad[7:0]] = 1'b1;
            d = '0;
            lat = 2;
          end else begin
            d = ref_vld[ad[7:0]] ? ref_mem[ad[7:0]] : pat(ad[7:0]);
            lat = 2 + LAT_A;
          end
          acc_q.push_back('{cyc + 1, we, ad, wd});
          sb_q.push_back('{m, d, cyc + lat});
        end
        if (mem_en) begin
          checks++;
          if (acc_q.size() == 0) begin
            errors++;
            $display("FAIL mem_access cyc=%0d unexpected mem_en addr=%h", cyc, mem_addr);
          end else begin
            a = acc_q.pop_front();
            if (a.c != cyc || mem_we !== a.we || mem_addr !== a.a || (a.we && mem_wdata !== a.w)) begin
              errors++;
              $display("FAIL mem_access got cyc=%0d we=%b addr=%h wdata=%h required cyc=%0d we=%b addr=%h wdata=%h",
                       cyc, mem_we, mem_addr, mem_wdata, a.c, a.we, a.a, a.w);
            end
          end
        end
        for (int i = 0; i < 2; i++) begin
          rv = (i == 0) ? m0_rvalid : m1_rvalid;
          rd = (i == 0) ? m0_rdata : m1_rdata;
          if (rv) begin
            checks++;
            if (sb_q.size() == 0) begin
              errors++;
              $display("FAIL rvalid cyc=%0d unexpected m%0d_rvalid rdata=%h", cyc, i, rd);
            end else begin
              r = sb_q.pop_front();
              if (r.m != i || r.c != cyc || rd !== r.d) begin
                errors++;
                $display("FAIL rvalid got m%0d cyc=%0d rdata=%h required m%0d cyc=%0d rdata=%h",
                         i, cyc, rd, r.m, r.c, r.d);
              end
            end
          end
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0;
    b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0;
`ifdef DATA_MEM_ARB_PERF_EN
    perf_clr = 0; b_perf_clr = 0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we});
    end
    checks++;
    if (m0_rdata !== 0 || m1_rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
      errors++;
      $display("FAIL reset_data got m0_rdata=%h m1_rdata=%h mem_addr=%h mem_wdata=%h required all 0",
               m0_rdata, m1_rdata, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_m0_read;
    logic got;
    m0_we = 0; m0_addr = 32'h10;
    @(posedge clk); #1;
    m0_req = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = m0_gnt;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL m0_read_gnt got no m0_gnt required m0_gnt"); end
    @(posedge clk); #1;
    m0_req = 0;
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL m0_read_drain pending=%0d required 0", sb_q.size()); end
    repeat (2) @(negedge clk);
    checks++;
    if (m0_rdata !== 32'hDEAD_BEEF || m1_rdata !== 0) begin
      errors++;
      $display("FAIL m0_read_hold got m0_rdata=%h m1_rdata=%h required deadbeef 0", m0_rdata, m1_rdata);
    end
  endtask

  // m1 writes 0x55 to 0x20, then reads it back through m1 so m1 owns the last grant.
  task automatic test_m1_write;
    logic got;
    for (int t = 0; t < 2; t++) begin
      m1_we = (t == 0); m1_addr = 32'h20; m1_wdata = 32'h55;
      @(posedge clk); #1;
      m1_req = 1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = m1_gnt;
      end
      checks++;
      if (!got) begin errors++; $display("FAIL m1_write_gnt step=%0d got no m1_gnt required m1_gnt", t); end
      @(posedge clk); #1;
      m1_req = 0;
      for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL m1_write_drain step=%0d pending=%0d required 0", t, sb_q.size()); end
    end
    checks++;
    if (m1_rdata !== 32'h55) begin errors++; $display("FAIL m1_readback got %h required 00000055", m1_rdata); end
  endtask

  task automatic test_round_robin;
    int order[4];
    int n;
    logic g0, g1;
    n = 0;
    m0_we = 0; m0_addr = 32'h40; m1_we = 0; m1_addr = 32'h50;
    @(posedge clk); #1;
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 80 && n < 4; i++) begin
      @(negedge clk);
      g0 = m0_gnt; g1 = m1_gnt;
      if (g0) begin order[n] = 0; n++; end
      else if (g1) begin order[n] = 1; n++; end
      @(posedge clk); #1;
      if (g0) m0_addr = m0_addr + 32'd4;
      if (g1) m1_addr = m1_addr + 32'd4;
    end
    m0_req = 0; m1_req = 0;
    checks++;
    if (n != 4) begin errors++; $display("FAIL rr_count got %0d grants required 4", n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k < n && order[k] != (k % 2)) begin
        errors++;
        $display("FAIL rr_order grant %0d got m%0d required m%0d", k, order[k], k % 2);
      end
    end
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL rr_drain pending=%0d required 0", sb_q.size()); end
  endtask

  task automatic test_lat3;
    logic got;
    int en_k, rv0_k, g1_k, rv1_k, n_rv0;
    logic [31:0] rd0, rd1;
    en_k = -1; rv0_k = -1; g1_k = -1; rv1_k = -1; n_rv0 = 0; rd0 = 0; rd1 = 0;
    b_m0_we = 0; b_m0_addr = 32'h10; b_m1_we = 0; b_m1_addr = 32'h11;
    @(posedge clk); #1;
    b_m0_req = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = b_m0_gnt;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL lat3_gnt got no m0_gnt required m0_gnt"); end
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 1) b_m0_req = 0;
      if (k == 3) b_m1_req = 1;   // raised while the m0 read sits in WAIT
      if (g1_k > 0) b_m1_req = 0;
      @(negedge clk);
      if (b_mem_en && en_k < 0) en_k = k;
      if (b_m0_rvalid) begin n_rv0++; rv0_k = k; rd0 = b_m0_rdata; end
      if (b_m1_gnt && g1_k < 0) g1_k = k;
      if (b_m1_rvalid && rv1_k < 0) begin rv1_k = k; rd1 = b_m1_rdata; end
    end
    checks++;
    if (en_k != 1) begin errors++; $display("FAIL lat3_mem_en got cycle %0d required 1", en_k); end
    checks++;
    if (rv0_k != 5 || n_rv0 != 1) begin
      errors++; $display("FAIL lat3_rvalid got cycle %0d count %0d required cycle 5 count 1", rv0_k, n_rv0);
    end
    checks++;
    if (rd0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lat3_rdata got %h required deadbeef", rd0); end
    checks++;
    if (g1_k != 6) begin errors++; $display("FAIL lat3_m1_gnt got cycle %0d required 6", g1_k); end
    checks++;
    if (rv1_k != 11 || rd1 !== 32'hC0FFEE11) begin
      errors++; $display("FAIL lat3_m1_rvalid got cycle %0d rdata %h required cycle 11 rdata c0ffee11", rv1_k, rd1);
    end
  endtask

  task automatic test_reset_mid;
    logic got;
    int n_rv;
    m0_we = 0; m0_addr = 32'h60;
    @(posedge clk); #1;
    m0_req = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = m0_gnt;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rstmid_gnt got no m0_gnt required m0_gnt"); end
    @(posedge clk); #1;
    m0_req = 0;
    @(posedge clk); #1;          // now in WAIT
    rst = 1'b0;
    sb_q.delete();
    acc_q.delete();
    #1;
    checks++;
    if ({mem_en, mem_we, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt} !== 6'b0 || m0_rdata !== 0 || mem_addr !== 0) begin
      errors++;
      $display("FAIL rstmid_outputs got ctrl=%b m0_rdata=%h mem_addr=%h required all 0",
               {mem_en, mem_we, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt}, m0_rdata, mem_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    n_rv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m0_rvalid) n_rv++;
    end
    checks++;
    if (n_rv != 0) begin errors++; $display("FAIL rstmid_no_rvalid got %0d pulses required 0", n_rv); end
    m0_addr = 32'h70; m1_addr = 32'h71; m1_we = 0;
    @(posedge clk); #1;
    m0_req = 1; m1_req = 1;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      errors++; $display("FAIL rstmid_tie got m0_gnt=%b m1_gnt=%b required 1 0", m0_gnt, m1_gnt);
    end
    @(posedge clk); #1;
    m0_req = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = m1_gnt;
    end
    @(posedge clk); #1;
    m1_req = 0;
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (!got || sb_q.size() != 0) begin
      errors++; $display("FAIL rstmid_drain got m1_gnt=%b pending=%0d required 1 0", got, sb_q.size());
    end
  endtask

`ifdef DATA_MEM_ARB_PERF_EN
  task automatic test_perf;
    logic got;
    @(posedge clk); #1;
    perf_clr = 1;
    @(posedge clk); #1;
    perf_clr = 0;
    @(negedge clk);
    checks++;
    if (perf_m0_cnt !== 0 || perf_m1_cnt !== 0) begin
      errors++; $display("FAIL perf_clr0 got %0d %0d required 0 0", perf_m0_cnt, perf_m1_cnt);
    end
    for (int t = 0; t < 7; t++) begin
      m0_we = 1; m0_addr = 32'h80 + t; m0_wdata = t;
      m1_we = 1; m1_addr = 32'h90 + t; m1_wdata = t;
      @(posedge clk); #1;
      if (t < 5) m0_req = 1; else m1_req = 1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = m0_gnt | m1_gnt;
      end
      @(posedge clk); #1;
      m0_req = 0; m1_req = 0;
      for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    end
    checks++;
    if (perf_m0_cnt !== 5 || perf_m1_cnt !== 2) begin
      errors++; $display("FAIL perf_count got %0d %0d required 5 2", perf_m0_cnt, perf_m1_cnt);
    end
    @(posedge clk); #1;
    perf_clr = 1;
    @(posedge clk); #1;
    perf_clr = 0;
    @(negedge clk);
    checks++;
    if (perf_m0_cnt !== 0 || perf_m1_cnt !== 0) begin
      errors++; $display("FAIL perf_clr1 got %0d %0d required 0 0", perf_m0_cnt, perf_m1_cnt);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    test_reset();
    test_m0_read();
    test_m1_write();
    test_round_robin();
    test_lat3();
    test_reset_mid();
`ifdef DATA_MEM_ARB_PERF_EN
    test_perf();
`endif
    repeat (4) @(negedge clk);
    checks++;
    if (sb_q.size() != 0 || acc_q.size() != 0) begin
      errors++; $display("FAIL final_drain got rsp=%0d acc=%0d pending required 0 0", sb_q.size(), acc_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares one single-port data memory between two requesters with a round-robin policy.
- Master 0 is the CPU data port (address, store data, write enable from the CPU core). Master 1 is a debug/loader port.
- A small FSM sequences each access through issue, fixed-latency wait and response phases.
- Sits between the CPU core, the debug loader and the data memory in the top-level SoC.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, cycles from mem_en high to valid mem_rdata; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- m0_req  input  1  master 0 request; held with m0_we/m0_addr/m0_wdata until m0_gnt seen high at a rising edge.
- m0_we  input  1  master 0 write (1) / read (0).
- m0_addr  input  AW  master 0 address.
- m0_wdata  input  DW  master 0 write data.
- m0_gnt  output  1  master 0 request accepted this cycle (combinational, IDLE only).
- m0_rvalid  output  1  one-cycle completion pulse; read data or write ack.
- m0_rdata  output  DW  read data, valid with m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_* for master 1.
- mem_en  output  1  memory access strobe, one cycle per transaction.
- mem_we  output  1  memory write enable, qualified by mem_en.
- mem_addr  output  AW  memory address (registered).
- mem_wdata  output  DW  memory write data (registered).
- mem_rdata  input  DW  memory read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0; rr_last=1, so master 0 wins the first tie.
  - Any in-flight transaction is dropped; no rvalid is issued for it.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - gnt is driven combinationally from req. Only one gnt may be high, and only in IDLE.
  - Single requester: it is granted.
  - Both requesting: grant the master != rr_last.
  - At the edge where a gnt is high: latch owner, we, addr and wdata; rr_last <= owner; next state ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - mem_en=1; mem_we/mem_addr/mem_wdata driven from the latched registers.
  - Write: next state RESP.
  - Read: next state WAIT, with cnt loaded to MEM_LAT-1.
- WAIT:
  - mem_en=0.
  - If cnt==0: capture mem_rdata into rdata_q and go to RESP.
  - Otherwise: cnt decrements.
- RESP:
  - owner's rvalid=1 for exactly one cycle; rdata = rdata_q for reads, 0 for writes.
  - The other master's rvalid stays 0.
  - Next state IDLE; new grants are possible the following cycle.
- Latency, with the grant edge at cycle 0:
  - read: mem_en in cycle 1, rvalid in cycle 2+MEM_LAT.
  - write: mem_en in cycle 1, rvalid in cycle 2.
- Throughput: at most one transaction every 3 cycles for writes and every 3+MEM_LAT cycles for reads. There is no pipelining.
- Requests raised while not in IDLE are ignored until IDLE; the requester keeps req held.
- Dropping req before gnt is legal and has no effect.
- Fairness: a continuously requesting master waits at most one foreign transaction.
- mN_rdata holds its value between rvalid pulses.
- mem_addr/mem_wdata hold their value outside ACCESS. Only mem_en qualifies them.
- cnt width is 4 bits. MEM_LAT outside 1..15 is a configuration error, flagged by an elaboration-time check.

Optional Feature:
- Macro: DATA_MEM_ARB_PERF_EN.
- When defined:
  - Adds input perf_clr (1) and outputs perf_m0_cnt (32) and perf_m1_cnt (32).
  - Each counter increments on its master's granted edge and saturates at 32'hFFFFFFFF.
  - perf_clr=1 zeroes both counters synchronously and takes priority over an increment.
  - Counters reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- MEM_LAT=1: m0 read of addr 0x10, with memory returning 0xDEADBEEF -> m0_gnt at cycle 0, mem_en/addr 0x10 at cycle 1, m0_rvalid with 0xDEADBEEF at cycle 3, m1_rvalid never high.
- m1 write of 0x00000055 to 0x20 -> mem_en=1, mem_we=1, mem_wdata=0x55 at cycle 1; m1_rvalid at cycle 2 with rdata 0.
- Both masters hold req continuously for 4 reads -> grant order m0, m1, m0, m1; never both gnt in one cycle.
- MEM_LAT=3: m0 read -> exactly 3 WAIT cycles, rvalid at cycle 5; a req from m1 during WAIT gets gnt only in the cycle after RESP.
- rst asserted low during WAIT of an m0 read -> outputs 0 immediately, no m0_rvalid after release; the first tie after release goes to m0.
- DATA_MEM_ARB_PERF_EN defined: 5 m0 grants and 2 m1 grants -> perf_m0_cnt=5, perf_m1_cnt=2; perf_clr for one cycle -> both 0.
